// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU.
// Single-cycle logic/arith/shift/compare ops plus a multi-cycle
// shift-add unsigned multiply. The result and the flags are held
// stable while the consumer stalls.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] reg_1,
    input  logic [WIDTH-1:0] reg_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             neg_flag,
    output logic             ovf_flag
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTS = 4'b1010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [SHW-1:0]     cnt_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] psum_s;
    logic [WIDTH-1:0]   mplier_r;

    logic [WIDTH-1:0]   out_r;
    logic               zero_r;
    logic               carry_r;
    logic               neg_r;
    logic               ovf_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               start_mul_s;
    logic               mul_done_s;
    logic               load_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_carry_s;
    logic               alu_ovf_s;
    logic [WIDTH-1:0]   ld_res_s;
    logic               ld_carry_s;
    logic               ld_ovf_s;

    // Handshake: accept only when idle and the output slot is free or draining.
    assign in_ready = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !rst;
    assign accept_s = in_valid && in_ready;

    assign shamt_s = reg_2[SHW-1:0];
    assign sum_s   = {1'b0, reg_1} + {1'b0, reg_2};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff_s  = {1'b0, reg_1} - {1'b0, reg_2};
    // Partial sum including the current multiplier bit; on the last step this is the product.
    assign psum_s  = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    assign out        = out_r;
    assign zero_flag  = zero_r;
    assign carry_flag = carry_r;
    assign neg_flag   = neg_r;
    assign ovf_flag   = ovf_r;
    assign out_valid  = out_valid_r;

    // Single-cycle result and carry/overflow candidates; MUL and unknown codes yield zero here.
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (alucont)
            OP_AND:  alu_res_s = reg_1 & reg_2;
            OP_OR:   alu_res_s = reg_1 | reg_2;
            OP_XOR:  alu_res_s = reg_1 ^ reg_2;
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (reg_1[WIDTH-1] == reg_2[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != reg_1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];
                alu_ovf_s   = (reg_1[WIDTH-1] != reg_2[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != reg_1[WIDTH-1]);
            end
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, (reg_1 < reg_2)};
            OP_SLTS: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(reg_1) < $signed(reg_2))};
            OP_SLL:  alu_res_s = reg_1 << shamt_s;
            OP_SRL:  alu_res_s = reg_1 >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(reg_1) >>> shamt_s);
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next state: enter MUL on a MUL accept, leave after the last multiplier bit.
    always_comb begin
        state_s     = state_r;
        start_mul_s = 1'b0;
        mul_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (alucont == OP_MUL)) begin
                    state_s     = ST_MUL;
                    start_mul_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_s    = ST_IDLE;
                    mul_done_s = 1'b1;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Select what the output register loads: a finished product or a single-cycle result.
    always_comb begin
        load_s     = 1'b0;
        ld_res_s   = alu_res_s;
        ld_carry_s = alu_carry_s;
        ld_ovf_s   = alu_ovf_s;
        if (mul_done_s) begin
            load_s     = 1'b1;
            ld_res_s   = psum_s[WIDTH-1:0];
            ld_carry_s = |psum_s[2*WIDTH-1:WIDTH];
            ld_ovf_s   = 1'b0;
        end else if (accept_s && !start_mul_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift-add multiplier: multiplicand moves left, multiplier moves right, one bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {SHW{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (start_mul_s) begin
            cnt_r    <= {SHW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, reg_1};
            mplier_r <= reg_2;
            acc_r    <= {(2*WIDTH){1'b0}};
        end else if (state_r == ST_MUL) begin
            cnt_r    <= mul_done_s ? {SHW{1'b0}} : cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= psum_s;
        end else begin
            cnt_r    <= cnt_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

    // Output register: load on a new result, drop valid on consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r       <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_r       <= ld_res_s;
            zero_r      <= (ld_res_s == {WIDTH{1'b0}});
            carry_r     <= ld_carry_s;
            neg_r       <= ld_res_s[WIDTH-1];
            ovf_r       <= ld_ovf_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16 against a
// plain-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  alucont;
    logic [15:0] reg_1;
    logic [15:0] reg_2;
    logic        sel16;

    logic        in_valid8, in_ready8, out_valid8, z8, c8, n8, v8;
    logic [7:0]  out8;
    logic        in_valid16, in_ready16, out_valid16, z16, c16, n16, v16;
    logic [15:0] out16;

    logic        obs_in_ready, obs_out_valid, obs_z, obs_c, obs_n, obs_v;
    logic [15:0] obs_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign in_valid8  = in_valid && !sel16;
    assign in_valid16 = in_valid && sel16;

    assign obs_in_ready  = sel16 ? in_ready16  : in_ready8;
    assign obs_out_valid = sel16 ? out_valid16 : out_valid8;
    assign obs_out       = sel16 ? out16 : {8'h00, out8};
    assign obs_z         = sel16 ? z16 : z8;
    assign obs_c         = sel16 ? c16 : c8;
    assign obs_n         = sel16 ? n16 : n8;
    assign obs_v         = sel16 ? v16 : v8;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .alucont(alucont), .reg_1(reg_1[7:0]), .reg_2(reg_2[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
        .zero_flag(z8), .carry_flag(c8), .neg_flag(n8), .ovf_flag(v8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .alucont(alucont), .reg_1(reg_1), .reg_2(reg_2),
        .out_valid(out_valid16), .out_ready(out_ready), .out(out16),
        .zero_flag(z16), .carry_flag(c16), .neg_flag(n16), .ovf_flag(v16)
    );

    // Reference model: integer arithmetic on w-bit values held in 64-bit containers.
    function automatic void ref_alu(input int w, input logic [3:0] op,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned r,
                                    output bit z, output bit c, output bit n, output bit v);
        longint unsigned mask;
        longint unsigned full;
        longint sa;
        longint sb;
        int sh;
        bit sgn_a;
        bit sgn_b;
        bit sgn_r;
        mask  = (64'd1 << w) - 64'd1;
        sgn_a = ((a >> (w - 1)) & 64'd1) != 64'd0;
        sgn_b = ((b >> (w - 1)) & 64'd1) != 64'd0;
        sa    = sgn_a ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb    = sgn_b ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        sh    = int'(b % longint'(w));
        r = 64'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd5:  r = a ^ b;
            4'd2: begin
                full = a + b;
                r = full & mask;
                c = full > mask;
            end
            4'd6: begin
                r = (a - b) & mask;
                c = a < b;
            end
            4'd7:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd3:  r = (a << sh) & mask;
            4'd4:  r = a >> sh;
            4'd9:  r = $unsigned(sa >>> sh) & mask;
            4'd8: begin
                full = a * b;
                r = full & mask;
                c = (full >> w) != 64'd0;
            end
            default: r = 64'd0;
        endcase
        sgn_r = ((r >> (w - 1)) & 64'd1) != 64'd0;
        if (op == 4'd2) v = (sgn_a == sgn_b) && (sgn_r != sgn_a);
        if (op == 4'd6) v = (sgn_a != sgn_b) && (sgn_r != sgn_a);
        z = (r == 64'd0);
        n = sgn_r;
    endfunction

    // Issue one op to the selected DUT and wait for its result; k = edges after accept.
    task automatic exec_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [3:0] f,
                           output int k, output bit leak);
        int nw;
        leak = 1'b0;
        k = 0;
        nw = 0;
        @(negedge clk);
        alucont = op; reg_1 = a; reg_2 = b; in_valid = 1'b1;
        while (!obs_in_ready && nw < 100) begin
            @(negedge clk);
            nw++;
        end
        checks++;
        if (nw >= 100) begin
            failures++;
            $display("FAIL accept_timeout op=%h got_waited=%0d limit=100", op, nw);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (!obs_out_valid && k < 200) begin
            if (obs_in_ready) leak = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL result_timeout op=%h got_cycles=%0d limit=200", op, k);
        end
        r = obs_out;
        f = {obs_z, obs_c, obs_n, obs_v};
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid8, out8, z8, c8, n8, v8, in_ready8} !== 14'd0) begin
            failures++;
            $display("FAIL reset8 got=%h exp=0", {out_valid8, out8, z8, c8, n8, v8, in_ready8});
        end
        checks++;
        if ({out_valid16, out16, z16, c16, n16, v16, in_ready16} !== 22'd0) begin
            failures++;
            $display("FAIL reset16 got=%h exp=0", {out_valid16, out16, z16, c16, n16, v16, in_ready16});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", in_ready8);
        end
    endtask

    // Reset asserted for two cycles in the middle of a multiply.
    task automatic test_reset_mid_mul();
        bit seen;
        int nw;
        sel16 = 1'b0; out_ready = 1'b1; nw = 0;
        @(negedge clk);
        alucont = 4'd8; reg_1 = 16'h0035; reg_2 = 16'h0077; in_valid = 1'b1;
        while (!obs_in_ready && nw < 100) begin
            @(negedge clk);
            nw++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({obs_in_ready, obs_out_valid, obs_out, obs_z, obs_c, obs_n, obs_v} !== 22'd0) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=0", i,
                         {obs_in_ready, obs_out_valid, obs_out, obs_z, obs_c, obs_n, obs_v});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_mid_reset got=%b exp=1", obs_in_ready);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (obs_out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL aborted_mul_valid got=%b exp=0", seen);
        end
    endtask

    task automatic test_add_sub_cmp();
        logic [15:0] r;
        logic [3:0] f;
        int k;
        bit leak;
        sel16 = 1'b0; out_ready = 1'b1;
        exec_op(4'd2, 16'h007F, 16'h0001, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0080, 4'b0011}) begin failures++; $display("FAIL add_ovf got=%h/%b exp=0080/0011", r, f); end
        exec_op(4'd2, 16'h00FF, 16'h0001, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0000, 4'b1100}) begin failures++; $display("FAIL add_carry got=%h/%b exp=0000/1100", r, f); end
        exec_op(4'd6, 16'h0003, 16'h0005, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h00FE, 4'b0110}) begin failures++; $display("FAIL sub_borrow got=%h/%b exp=00fe/0110", r, f); end
        exec_op(4'd7, 16'h0080, 16'h0001, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0000, 4'b1000}) begin failures++; $display("FAIL slt got=%h/%b exp=0000/1000", r, f); end
        exec_op(4'd10, 16'h0080, 16'h0001, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0001, 4'b0000}) begin failures++; $display("FAIL slts got=%h/%b exp=0001/0000", r, f); end
        checks++;
        if (k !== 0) begin failures++; $display("FAIL single_latency got=%0d exp=0", k); end
    endtask

    task automatic test_shifts();
        logic [15:0] r;
        logic [3:0] f;
        int k;
        bit leak;
        sel16 = 1'b0; out_ready = 1'b1;
        exec_op(4'd9, 16'h0090, 16'h000B, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h00F2, 4'b0010}) begin failures++; $display("FAIL sra got=%h/%b exp=00f2/0010", r, f); end
        exec_op(4'd3, 16'h0081, 16'h0001, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0002, 4'b0000}) begin failures++; $display("FAIL sll got=%h/%b exp=0002/0000", r, f); end
    endtask

    task automatic test_mul();
        logic [15:0] r;
        logic [3:0] f;
        int k;
        bit leak;
        sel16 = 1'b0; out_ready = 1'b1;
        exec_op(4'd8, 16'h0010, 16'h0011, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0010, 4'b0100}) begin failures++; $display("FAIL mul_hi got=%h/%b exp=0010/0100", r, f); end
        checks++;
        if (k !== 8) begin failures++; $display("FAIL mul_latency got=%0d exp=8", k); end
        checks++;
        if (leak !== 1'b0) begin failures++; $display("FAIL mul_ready_busy got=%b exp=0", leak); end
        exec_op(4'd8, 16'h000F, 16'h000F, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h00E1, 4'b0010}) begin failures++; $display("FAIL mul_lo got=%h/%b exp=00e1/0010", r, f); end
    endtask

    task automatic test_random(input int w, input int count);
        logic [15:0] r;
        logic [3:0] f;
        logic [3:0] op;
        logic [15:0] a;
        logic [15:0] b;
        longint unsigned er;
        bit ez, ec, en, ev;
        int k;
        bit leak;
        sel16 = (w == 16); out_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom) & ((w == 16) ? 16'hFFFF : 16'h00FF);
            b  = 16'($urandom) & ((w == 16) ? 16'hFFFF : 16'h00FF);
            exec_op(op, a, b, r, f, k, leak);
            ref_alu(w, op, longint'(a), longint'(b), er, ez, ec, en, ev);
            checks++;
            if ({r, f} !== {er[15:0], ez, ec, en, ev}) begin
                failures++;
                $display("FAIL rand_w%0d op=%h a=%h b=%h got=%h/%b exp=%h/%b",
                         w, op, a, b, r, f, er[15:0], {ez, ec, en, ev});
            end
            checks++;
            if (k !== ((op == 4'd8) ? w : 0) || leak !== 1'b0) begin
                failures++;
                $display("FAIL rand_timing_w%0d op=%h got_lat=%0d leak=%b exp_lat=%0d",
                         w, op, k, leak, (op == 4'd8) ? w : 0);
            end
        end
    endtask

    // ADD result held under back-pressure, then four ANDs streamed at full rate.
    task automatic test_back_to_back(input int w);
        logic [15:0] r;
        logic [3:0] f;
        logic [15:0] held;
        logic [15:0] sa [4];
        logic [15:0] sb [4];
        logic [15:0] msk;
        longint unsigned er;
        bit ez, ec, en, ev;
        int k;
        bit leak;
        sel16 = (w == 16); out_ready = 1'b1;
        msk = (w == 16) ? 16'hFFFF : 16'h00FF;
        repeat (2) @(posedge clk);
        out_ready = 1'b0;
        exec_op(4'd2, 16'($urandom) & msk, 16'($urandom) & msk, r, f, k, leak);
        ref_alu(w, 4'd2, longint'(reg_1), longint'(reg_2), er, ez, ec, en, ev);
        checks++;
        if ({r, f} !== {er[15:0], ez, ec, en, ev}) begin
            failures++;
            $display("FAIL bp_add_w%0d got=%h/%b exp=%h/%b", w, r, f, er[15:0], {ez, ec, en, ev});
        end
        held = r;
        for (int i = 0; i < 4; i++) begin
            sa[i] = 16'($urandom) & msk;
            sb[i] = 16'($urandom) & msk;
        end
        @(negedge clk);
        alucont = 4'd0; reg_1 = sa[0]; reg_2 = sb[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({obs_out, obs_out_valid, obs_in_ready} !== {held, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold_w%0d cyc=%0d got=%h/%b/%b exp=%h/1/0",
                         w, i, obs_out, obs_out_valid, obs_in_ready, held);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({obs_out_valid, obs_out} !== {1'b1, sa[i] & sb[i]}) begin
                failures++;
                $display("FAIL stream_w%0d idx=%0d got=%b/%h exp=1/%h",
                         w, i, obs_out_valid, obs_out, sa[i] & sb[i]);
            end
            if (i < 3) begin
                reg_1 = sa[i + 1];
                reg_2 = sb[i + 1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain_w%0d got=%b exp=0", w, obs_out_valid);
        end
    endtask

    task automatic test_width16();
        logic [15:0] r;
        logic [3:0] f;
        int k;
        bit leak;
        test_back_to_back(16);
        sel16 = 1'b1; out_ready = 1'b1;
        exec_op(4'd8, 16'hFFFF, 16'hFFFF, r, f, k, leak);
        checks++;
        if ({r, f} !== {16'h0001, 4'b0100}) begin failures++; $display("FAIL mul16 got=%h/%b exp=0001/0100", r, f); end
        checks++;
        if (k !== 16 || leak !== 1'b0) begin failures++; $display("FAIL mul16_timing got=%0d/%b exp=16/0", k, leak); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel16 = 1'b0;
        alucont = 4'd0; reg_1 = 16'h0000; reg_2 = 16'h0000;
        test_reset();
        test_add_sub_cmp();
        test_shifts();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back(8);
        test_random(8, 60);
        test_width16();
        test_random(16, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked, width-parametrised ALU for the datapath. It is the next-generation replacement for the 8-bit combinational ALU. It adds shifts, signed compare, a multi-cycle unsigned multiply and a full flag set (zero, carry, negative, overflow). It sits between operand fetch and writeback, and uses valid/ready on both sides so a stalled writeback back-pressures issue.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts operation this cycle.
- alucont  in  4  operation select.
- reg_1  in  WIDTH  operand A.
- reg_2  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result this cycle.
- out  out  WIDTH  result.
- zero_flag  out  1  out == 0.
- carry_flag  out  1  carry/borrow or multiply high-half nonzero.
- neg_flag  out  1  out[WIDTH-1].
- ovf_flag  out  1  signed overflow (add/sub only).

## Operation
- Accept occurs when in_valid && in_ready. in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0101 XOR; 0110 SUB (A−B); 0111 SLT, unsigned (1 if A<B, else 0).
  - 0011 SLL; 0100 SRL; 1001 SRA. The shift amount is reg_2[$clog2(WIDTH)-1:0]; upper bits are ignored.
  - 1010 SLTS: signed less-than.
  - 1000 MUL: unsigned; out is the low WIDTH bits of the product.
  - Any other code: out = 0 and all flags 0 except zero_flag = 1.
- Flags:
  - zero_flag = (out == 0).
  - neg_flag = out MSB.
  - carry_flag:
    - ADD: carry out of the MSB.
    - SUB: borrow, i.e. 1 when A<B unsigned.
    - MUL: 1 when any bit of product[2*WIDTH-1:WIDTH] is set.
    - All other ops: 0.
  - ovf_flag:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from A.
    - All other ops: 0.
- FSM states:
  - IDLE:
    - Accepting a non-MUL op loads out and all flags and sets out_valid; the state stays IDLE.
    - Accepting MUL latches A, B and clears the accumulator; the state goes to MUL with cnt = 0.
  - MUL: shift-add, one bit of B per cycle, LSB first. The accumulator is 2*WIDTH wide.
    - cnt increments each cycle.
    - When cnt == WIDTH-1, the final partial sum loads out and the flags, sets out_valid, and returns the state to IDLE.
- Output hold: while out_valid && !out_ready, out and all flags stay stable, and no new op is accepted.
- out_valid clears on out_ready unless a new op is accepted in the same cycle. That op's single-cycle result replaces the old one, and out_valid stays 1.
- Simultaneous events: out_ready with a new accept in the same cycle gives back-to-back results at full throughput for single-cycle ops.
- in_valid during MUL is ignored (in_ready = 0). The source must hold its op.

## Timing
- Reset values: out = 0, all flags 0, out_valid = 0, state IDLE, cnt = 0. in_ready = 0 while rst is high and 1 on the first cycle after.
- Reset during MUL aborts the multiply. The partial product is discarded and no out_valid is produced.
- Single-cycle ops: accept at edge N, then out_valid = 1 and the result is visible after edge N (latency 1).
- MUL: accept at edge N, then out_valid = 1 after edge N+WIDTH. in_ready = 0 for cycles N+1..N+WIDTH.
- Throughput:
  - Single-cycle ops: 1 op/cycle when out_ready is held high.
  - MUL: 1 per WIDTH+1 cycles.
- No combinational path from reg_1, reg_2 or alucont to any output. in_ready depends combinationally on out_ready.

## Test plan
WIDTH = 8 unless stated.

- Reset: assert rst for 2 cycles mid-stream -> out = 0, flags 0, out_valid = 0, in_ready = 0 during reset; in_ready = 1 on the next cycle.
- ADD overflow/carry:
  - 0x7F + 0x01 -> out 0x80, ovf 1, neg 1, carry 0.
  - 0xFF + 0x01 -> out 0x00, zero 1, carry 1, ovf 0.
- SUB and compares:
  - 0x03 − 0x05 -> out 0xFE, carry (borrow) 1, neg 1.
  - SLT(0x80, 0x01) -> out 0.
  - SLTS(0x80, 0x01) -> out 1.
- Shifts:
  - SRA 0x90 by 0x0B (the field is reg_2[2:0] = 3) -> out 0xF2.
  - SLL 0x81 by 1 -> out 0x02.
- MUL:
  - 0x10 × 0x11 -> out 0x10, carry 1, out_valid exactly 8 cycles after accept, in_ready 0 meanwhile.
  - 0x0F × 0x0F -> out 0xE1, carry 0.
- Back-pressure and throughput:
  - Hold out_ready = 0 for 3 cycles after an ADD result -> out stable, in_ready 0.
  - Then stream 4 ANDs with out_ready = 1 -> 4 results on 4 consecutive cycles.
  - Repeat the streaming check at WIDTH = 16 with a 0xFFFF × 0xFFFF MUL -> out 0x0001, carry 1.
